// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite row fetcher: walks NUM_SPR slots one ROM read per cycle, commits rows atomically.
// Optional horizontal flip per slot when SPRITE_HFLIP_EN is defined.
module sprite_line_fetcher #(
  parameter int NUM_SPR = 5,
  parameter int SPR_H   = 32
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   line_start,
  input  logic [9:0]             line_y,
  input  logic [NUM_SPR-1:0]     spr_en,
  input  logic [NUM_SPR*10-1:0]  spr_y,
  input  logic [NUM_SPR*3-1:0]   spr_kind,
`ifdef SPRITE_HFLIP_EN
  input  logic [NUM_SPR-1:0]     spr_hflip,
`endif
  output logic [7:0]             rom_addr,
  input  logic [31:0]            rom_data,
  output logic [NUM_SPR*32-1:0]  row_data,
  output logic [NUM_SPR-1:0]     row_hit,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPR - 1);
  localparam logic [9:0] HEIGHT = 10'(SPR_H);

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [9:0]              snap_line;
  logic [NUM_SPR-1:0]      snap_en;
  logic [NUM_SPR*10-1:0]   snap_y;
  logic [NUM_SPR*3-1:0]    snap_kind;
`ifdef SPRITE_HFLIP_EN
  logic [NUM_SPR-1:0]      snap_flip;
`endif
  logic [NUM_SPR*32-1:0]   shadow;
  logic [NUM_SPR-1:0]      shadow_hit;

  logic                    cur_en;
  logic [9:0]              cur_y;
  logic [2:0]              cur_kind;
  logic [9:0]              diff;
  logic                    hit;
  logic [31:0]             row_val;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_start) state_nxt = FETCH;
      FETCH:   if (idx == LAST_IDX) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Unsigned compare with no wrap: a sprite whose top lies below the line always misses.
  always_comb begin
    cur_en   = snap_en[idx];
    cur_y    = snap_y[idx*10 +: 10];
    cur_kind = snap_kind[idx*3 +: 3];
    diff     = snap_line - cur_y;
    hit      = (state == FETCH) && cur_en && (cur_kind <= 3'd4) &&
               (snap_line >= cur_y) && (diff < HEIGHT);
    rom_addr = hit ? ({cur_kind, 5'b0} + {3'b0, diff[4:0]}) : 8'd0;
    row_val  = hit ? rom_data : 32'd0;
`ifdef SPRITE_HFLIP_EN
    if (hit && snap_flip[idx]) begin
      for (int b = 0; b < 32; b++) row_val[b] = rom_data[31-b];
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx        <= '0;
      snap_line  <= '0;
      snap_en    <= '0;
      snap_y     <= '0;
      snap_kind  <= '0;
`ifdef SPRITE_HFLIP_EN
      snap_flip  <= '0;
`endif
      shadow     <= '0;
      shadow_hit <= '0;
      row_data   <= '0;
      row_hit    <= '0;
      done       <= 1'b0;
    end else begin
      if (state == IDLE && line_start) begin
        idx       <= '0;
        snap_line <= line_y;
        snap_en   <= spr_en;
        snap_y    <= spr_y;
        snap_kind <= spr_kind;
`ifdef SPRITE_HFLIP_EN
        snap_flip <= spr_hflip;
`endif
      end
      if (state == FETCH) begin
        shadow[idx*32 +: 32] <= row_val;
        shadow_hit[idx]      <= hit;
        idx                  <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (state == COMMIT) begin
        row_data <= shadow;
        row_hit  <= shadow_hit;
      end
      done <= (state == COMMIT);
    end
  end

endmodule
